// File: rtl/gci_std_kmc_pkg.sv
// Shared definitions for the keyboard/mouse controller: FSM encoding, PS/2 frame
// constants and default filter/timeout values used by the rx and tx controllers.
package gci_std_kmc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } kmc_rx_state_t;

    localparam int unsigned KMC_DATA_BITS       = 8;
    localparam logic        KMC_PARITY_ODD      = 1'b1;
    localparam int unsigned KMC_FILTER_DEFAULT  = 8;
    localparam int unsigned KMC_TIMEOUT_DEFAULT = 5000;

    // True when the eight data bits plus the parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [KMC_DATA_BITS-1:0] data, input logic par);
        return ((^{data, par}) == KMC_PARITY_ODD);
    endfunction

endpackage

// File: rtl/gci_std_kmc_synchronizer.sv
// Multi-stage flop synchroniser for asynchronous inputs; every stage resets to 0.
module gci_std_kmc_synchronizer #(
    parameter int unsigned P_N = 2,
    parameter int unsigned P_W = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           srst,
    input  logic [P_W-1:0] d,
    output logic [P_W-1:0] q
);

    logic [P_N-1:0][P_W-1:0] stage_r;

    // Shift chain: stage 0 captures the raw input, the last stage is the synced output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_r <= '0;
        end else if (srst) begin
            stage_r <= '0;
        end else begin
            stage_r <= {stage_r[P_N-2:0], d};
        end
    end

    assign q = stage_r[P_N-1];

endmodule

// File: rtl/gci_std_kmc_ps2_rx_ctrl.sv
// PS/2 receive controller: synchronise, deglitch the clock, sequence the 11-bit
// frame, check start/parity/stop and hand good bytes over a one-entry buffer.
module gci_std_kmc_ps2_rx_ctrl
    import gci_std_kmc_pkg::*;
#(
    parameter int unsigned P_FILTER  = KMC_FILTER_DEFAULT,
    parameter int unsigned P_TIMEOUT = KMC_TIMEOUT_DEFAULT
) (
    input  logic       iCLOCK,
    input  logic       inRESET,
    input  logic       iRESET_SYNC,
    input  logic       iPS2_CLK,
    input  logic       iPS2_DATA,
    output logic       oRD_VALID,
    output logic [7:0] oRD_DATA,
    input  logic       iRD_ACK,
    output logic       oERR_PARITY,
    output logic       oERR_FRAME,
    output logic       oERR_TIMEOUT,
    output logic       oERR_OVERFLOW,
    output logic       oBUSY
);

    localparam logic [7:0]  FILT_LAST = 8'(P_FILTER - 1);
    localparam logic [15:0] TMO_LAST  = 16'(P_TIMEOUT - 1);

    logic [1:0]    sync_s;
    logic          ps2_clk_s, ps2_data_s;
    logic          filt_r, filt_nxt;
    logic [7:0]    filt_cnt_r, filt_cnt_nxt;
    logic          fall_r, fall_nxt_s;
    kmc_rx_state_t state_r, state_nxt;
    logic [2:0]    bit_cnt_r, bit_cnt_nxt;
    logic [7:0]    shift_r, shift_nxt;
    logic          par_r, par_nxt;
    logic [15:0]   tmo_r, tmo_nxt, tmo_inc_s;
    logic          timeout_s, commit_s;
    logic          rd_valid_r, rd_valid_nxt;
    logic [7:0]    rd_data_r, rd_data_nxt;
    logic          err_parity_r, err_parity_nxt;
    logic          err_frame_r, err_frame_nxt;
    logic          err_timeout_r, err_timeout_nxt;
    logic          err_overflow_r, err_overflow_nxt;
    logic          busy_r;

    gci_std_kmc_synchronizer #(.P_N(2), .P_W(2)) u_sync (
        .clk   (iCLOCK),
        .rst_n (inRESET),
        .srst  (iRESET_SYNC),
        .d     ({iPS2_DATA, iPS2_CLK}),
        .q     (sync_s)
    );

    assign ps2_clk_s  = sync_s[0];
    assign ps2_data_s = sync_s[1];

    // Clock deglitcher: a new level must persist P_FILTER cycles before it is accepted.
    always_comb begin
        filt_nxt     = filt_r;
        filt_cnt_nxt = 8'd0;
        if (ps2_clk_s != filt_r) begin
            if (filt_cnt_r == FILT_LAST) begin
                filt_nxt = ~filt_r;
            end else begin
                filt_cnt_nxt = filt_cnt_r + 8'd1;
            end
        end else begin
            filt_cnt_nxt = 8'd0;
        end
    end

    assign fall_nxt_s = filt_r & ~filt_nxt;
    assign tmo_inc_s  = tmo_r + 16'd1;
    // The timeout counter restarts with each fall event, so a pending edge always wins.
    assign timeout_s  = (state_r != ST_IDLE) && !fall_r && !fall_nxt_s && (tmo_inc_s == TMO_LAST);

    // Frame sequencer and timeout supervision.
    always_comb begin
        state_nxt       = state_r;
        bit_cnt_nxt     = bit_cnt_r;
        shift_nxt       = shift_r;
        par_nxt         = par_r;
        tmo_nxt         = tmo_r;
        commit_s        = 1'b0;
        err_parity_nxt  = 1'b0;
        err_frame_nxt   = 1'b0;
        err_timeout_nxt = 1'b0;
        if ((state_r == ST_IDLE) || fall_nxt_s) begin
            tmo_nxt = 16'd0;
        end else begin
            tmo_nxt = tmo_inc_s;
        end
        if (fall_r) begin
            case (state_r)
                ST_IDLE: begin
                    if (!ps2_data_s) begin
                        state_nxt   = ST_DATA;
                        bit_cnt_nxt = 3'd0;
                    end else begin
                        err_frame_nxt = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_nxt   = {ps2_data_s, shift_r[7:1]};
                    bit_cnt_nxt = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        state_nxt = ST_PARITY;
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    par_nxt   = ps2_data_s;
                    state_nxt = ST_STOP;
                end
                ST_STOP: begin
                    state_nxt = ST_IDLE;
                    if (!ps2_data_s) begin
                        err_frame_nxt = 1'b1;
                    end else if (!odd_parity_ok(shift_r, par_r)) begin
                        err_parity_nxt = 1'b1;
                    end else begin
                        commit_s = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end else if (timeout_s) begin
            state_nxt       = ST_IDLE;
            err_timeout_nxt = 1'b1;
        end else begin
            state_nxt = state_r;
        end
    end

    // One-entry output buffer; an ack in the commit cycle frees the slot for the new byte.
    always_comb begin
        rd_valid_nxt     = rd_valid_r;
        rd_data_nxt      = rd_data_r;
        err_overflow_nxt = 1'b0;
        if (commit_s) begin
            if (!rd_valid_r || iRD_ACK) begin
                rd_data_nxt  = shift_r;
                rd_valid_nxt = 1'b1;
            end else begin
                err_overflow_nxt = 1'b1;
            end
        end else if (iRD_ACK) begin
            rd_valid_nxt = 1'b0;
        end else begin
            rd_valid_nxt = rd_valid_r;
        end
    end

    // State register for filter, sequencer, timeout and registered outputs.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            filt_r <= 1'b1; filt_cnt_r <= 8'd0; fall_r <= 1'b0;
            state_r <= ST_IDLE; bit_cnt_r <= 3'd0; shift_r <= 8'd0; par_r <= 1'b0;
            tmo_r <= 16'd0; rd_valid_r <= 1'b0; rd_data_r <= 8'd0;
            err_parity_r <= 1'b0; err_frame_r <= 1'b0; err_timeout_r <= 1'b0;
            err_overflow_r <= 1'b0; busy_r <= 1'b0;
        end else if (iRESET_SYNC) begin
            filt_r <= 1'b1; filt_cnt_r <= 8'd0; fall_r <= 1'b0;
            state_r <= ST_IDLE; bit_cnt_r <= 3'd0; shift_r <= 8'd0; par_r <= 1'b0;
            tmo_r <= 16'd0; rd_valid_r <= 1'b0; rd_data_r <= 8'd0;
            err_parity_r <= 1'b0; err_frame_r <= 1'b0; err_timeout_r <= 1'b0;
            err_overflow_r <= 1'b0; busy_r <= 1'b0;
        end else begin
            filt_r <= filt_nxt; filt_cnt_r <= filt_cnt_nxt; fall_r <= fall_nxt_s;
            state_r <= state_nxt; bit_cnt_r <= bit_cnt_nxt; shift_r <= shift_nxt; par_r <= par_nxt;
            tmo_r <= tmo_nxt; rd_valid_r <= rd_valid_nxt; rd_data_r <= rd_data_nxt;
            err_parity_r <= err_parity_nxt; err_frame_r <= err_frame_nxt;
            err_timeout_r <= err_timeout_nxt; err_overflow_r <= err_overflow_nxt;
            busy_r <= (state_nxt != ST_IDLE);
        end
    end

    assign oRD_VALID     = rd_valid_r;
    assign oRD_DATA      = rd_data_r;
    assign oERR_PARITY   = err_parity_r;
    assign oERR_FRAME    = err_frame_r;
    assign oERR_TIMEOUT  = err_timeout_r;
    assign oERR_OVERFLOW = err_overflow_r;
    assign oBUSY         = busy_r;

endmodule

// File: tb/tb_gci_std_kmc_ps2_rx_ctrl.sv
// Self-checking bench for the PS/2 receive controller: directed scenarios plus
// randomized frames judged against a frame-level reference model.
module tb_gci_std_kmc_ps2_rx_ctrl;

    localparam int P_FILTER  = 4;
    localparam int P_TIMEOUT = 200;
    localparam int HALF      = 60;

    logic       iCLOCK = 1'b0, inRESET = 1'b0, iRESET_SYNC = 1'b0;
    logic       iPS2_CLK = 1'b1, iPS2_DATA = 1'b1, iRD_ACK = 1'b0;
    logic       oRD_VALID, oERR_PARITY, oERR_FRAME, oERR_TIMEOUT, oERR_OVERFLOW, oBUSY;
    logic [7:0] oRD_DATA;

    int errors = 0, checks = 0, cyc = 0;
    int n_par = 0, n_frm = 0, n_tmo = 0, n_ovf = 0, n_multi = 0, n_busy = 0;
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;

    gci_std_kmc_ps2_rx_ctrl #(.P_FILTER(P_FILTER), .P_TIMEOUT(P_TIMEOUT)) dut (
        .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
        .iPS2_CLK(iPS2_CLK), .iPS2_DATA(iPS2_DATA),
        .oRD_VALID(oRD_VALID), .oRD_DATA(oRD_DATA), .iRD_ACK(iRD_ACK),
        .oERR_PARITY(oERR_PARITY), .oERR_FRAME(oERR_FRAME), .oERR_TIMEOUT(oERR_TIMEOUT),
        .oERR_OVERFLOW(oERR_OVERFLOW), .oBUSY(oBUSY)
    );

    always #5 iCLOCK = ~iCLOCK;

    always @(posedge iCLOCK) cyc <= cyc + 1;

    // Pulse and busy-cycle counters sampled on the inactive edge.
    always @(negedge iCLOCK) begin
        n_par   <= n_par + int'(oERR_PARITY);
        n_frm   <= n_frm + int'(oERR_FRAME);
        n_tmo   <= n_tmo + int'(oERR_TIMEOUT);
        n_ovf   <= n_ovf + int'(oERR_OVERFLOW);
        n_busy  <= n_busy + int'(oBUSY);
        n_multi <= n_multi + int'((int'(oERR_PARITY) + int'(oERR_FRAME) + int'(oERR_TIMEOUT) + int'(oERR_OVERFLOW)) > 1);
    end

    function automatic logic odd_par(input logic [7:0] d);
        return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge iCLOCK);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        iPS2_DATA = b;
        wait_cycles(HALF / 2);
        iPS2_CLK = 1'b0;
        wait_cycles(HALF);
        iPS2_CLK = 1'b1;
        wait_cycles(HALF / 2);
    endtask

    task automatic do_ack();
        iRD_ACK = 1'b1;
        wait_cycles(1);
        iRD_ACK = 1'b0;
        m_valid = 1'b0;
        checks++;
        if (oRD_VALID !== 1'b0 || oRD_DATA !== m_data) begin
            errors++;
            $display("FAIL ack: valid=%b data=%h, required valid=0 data=%h", oRD_VALID, oRD_DATA, m_data);
        end
    endtask

    // Sends one full frame; the model decides the outcome from the frame bits alone.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input logic ack);
        int p0, f0, t0, o0, exp_p, exp_f, exp_o;
        logic pre_valid;
        p0 = n_par; f0 = n_frm; t0 = n_tmo; o0 = n_ovf;
        pre_valid = m_valid;
        exp_p = 0; exp_f = 0; exp_o = 0;
        if (!stp) exp_f = 1;
        else if (($countones(d) + int'(par)) % 2 == 0) exp_p = 1;
        else if (m_valid && !ack) exp_o = 1;
        if (exp_f == 0 && exp_p == 0 && exp_o == 0) begin
            m_valid = 1'b1;
            m_data  = d;
        end else if (ack) begin
            m_valid = 1'b0;
        end
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        iPS2_DATA = stp;
        wait_cycles(HALF / 2);
        iPS2_CLK = 1'b0;
        wait_cycles(P_FILTER + 2);
        checks++;
        if (oRD_VALID !== pre_valid || oBUSY !== 1'b1) begin
            errors++;
            $display("FAIL pre_commit: valid=%b busy=%b, required valid=%b busy=1", oRD_VALID, oBUSY, pre_valid);
        end
        iRD_ACK = ack;
        wait_cycles(1);
        iRD_ACK = 1'b0;
        checks++;
        if (oRD_VALID !== m_valid || oRD_DATA !== m_data || oBUSY !== 1'b0) begin
            errors++;
            $display("FAIL commit: valid=%b data=%h busy=%b, required valid=%b data=%h busy=0",
                     oRD_VALID, oRD_DATA, oBUSY, m_valid, m_data);
        end
        checks++;
        if ({oERR_PARITY, oERR_FRAME, oERR_TIMEOUT, oERR_OVERFLOW} !== {exp_p[0], exp_f[0], 1'b0, exp_o[0]}) begin
            errors++;
            $display("FAIL err_flags: p/f/t/o=%b%b%b%b, required %0d%0d0%0d",
                     oERR_PARITY, oERR_FRAME, oERR_TIMEOUT, oERR_OVERFLOW, exp_p, exp_f, exp_o);
        end
        wait_cycles(HALF - P_FILTER - 3);
        iPS2_CLK = 1'b1;
        wait_cycles(HALF / 2);
        iPS2_DATA = 1'b1;
        checks++;
        if ((n_par - p0) != exp_p || (n_frm - f0) != exp_f || (n_tmo - t0) != 0 || (n_ovf - o0) != exp_o) begin
            errors++;
            $display("FAIL pulse_counts: p/f/t/o=%0d/%0d/%0d/%0d, required %0d/%0d/0/%0d",
                     n_par - p0, n_frm - f0, n_tmo - t0, n_ovf - o0, exp_p, exp_f, exp_o);
        end
    endtask

    task automatic test_reset();
        wait_cycles(3);
        checks++;
        if ({oRD_VALID, oRD_DATA, oERR_PARITY, oERR_FRAME, oERR_TIMEOUT, oERR_OVERFLOW, oBUSY} !== 14'd0) begin
            errors++;
            $display("FAIL reset_hold: outputs=%b, required all 0",
                     {oRD_VALID, oRD_DATA, oERR_PARITY, oERR_FRAME, oERR_TIMEOUT, oERR_OVERFLOW, oBUSY});
        end
        inRESET = 1'b1;
        wait_cycles(10);
        checks++;
        if ({oRD_VALID, oRD_DATA, oBUSY} !== 10'd0 || (n_par + n_frm + n_tmo + n_ovf) != 0) begin
            errors++;
            $display("FAIL reset_release: valid=%b data=%h busy=%b pulses=%0d, required 0",
                     oRD_VALID, oRD_DATA, oBUSY, n_par + n_frm + n_tmo + n_ovf);
        end
    endtask

    task automatic test_basic();
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_parity();
        do_ack();
        send_frame(8'hAA, 1'b1, 1'b1, 1'b0);
        send_frame(8'h55, odd_par(8'h55), 1'b1, 1'b0);
    endtask

    task automatic test_frame();
        int f0;
        do_ack();
        f0 = n_frm;
        send_bit(1'b1);
        wait_cycles(5);
        checks++;
        if ((n_frm - f0) != 1 || oBUSY !== 1'b0) begin
            errors++;
            $display("FAIL start_bit_one: frame pulses=%0d busy=%b, required 1 and 0", n_frm - f0, oBUSY);
        end
        send_frame(8'h3C, odd_par(8'h3C), 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        int n0, t0, o0;
        t0 = n_tmo; o0 = n_par + n_frm + n_ovf;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        iPS2_DATA = 1'b1;
        wait_cycles(HALF / 2);
        iPS2_CLK = 1'b0;
        n0 = cyc;
        wait_cycles(HALF);
        iPS2_CLK = 1'b1;
        // Fall event rises P_FILTER+2 edges after the drive; timeout P_TIMEOUT-1 edges later.
        wait_cycles(n0 + P_FILTER + P_TIMEOUT - cyc);
        checks++;
        if (oERR_TIMEOUT !== 1'b0 || oBUSY !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: tmo=%b busy=%b, required 0 and 1", oERR_TIMEOUT, oBUSY);
        end
        wait_cycles(1);
        checks++;
        if (oERR_TIMEOUT !== 1'b1 || oBUSY !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: tmo=%b busy=%b, required 1 and 0", oERR_TIMEOUT, oBUSY);
        end
        wait_cycles(1);
        checks++;
        if (oERR_TIMEOUT !== 1'b0 || (n_tmo - t0) != 1 || (n_par + n_frm + n_ovf) != o0) begin
            errors++;
            $display("FAIL timeout_once: tmo=%b count=%0d other=%0d, required 0, 1, 0",
                     oERR_TIMEOUT, n_tmo - t0, n_par + n_frm + n_ovf - o0);
        end
        send_frame(8'hF0, odd_par(8'hF0), 1'b1, 1'b0);
    endtask

    task automatic test_overflow();
        do_ack();
        send_frame(8'h11, odd_par(8'h11), 1'b1, 1'b0);
        send_frame(8'h22, odd_par(8'h22), 1'b1, 1'b0);
        send_frame(8'h22, odd_par(8'h22), 1'b1, 1'b1);
    endtask

    task automatic test_glitch_reset();
        int e0, b0;
        e0 = n_par + n_frm + n_tmo + n_ovf;
        b0 = n_busy;
        for (int g = 0; g < 5; g++) begin
            iPS2_CLK = 1'b0;
            wait_cycles(2);
            iPS2_CLK = 1'b1;
            wait_cycles(20);
        end
        checks++;
        if ((n_par + n_frm + n_tmo + n_ovf) != e0 || n_busy != b0 || oRD_VALID !== m_valid) begin
            errors++;
            $display("FAIL glitch: err pulses=%0d busy cycles=%0d valid=%b, required 0, 0, %b",
                     n_par + n_frm + n_tmo + n_ovf - e0, n_busy - b0, oRD_VALID, m_valid);
        end
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        checks++;
        if (oBUSY !== 1'b1) begin
            errors++;
            $display("FAIL mid_frame_busy: busy=%b, required 1", oBUSY);
        end
        inRESET = 1'b0;
        #2;
        checks++;
        if ({oRD_VALID, oRD_DATA, oERR_PARITY, oERR_FRAME, oERR_TIMEOUT, oERR_OVERFLOW, oBUSY} !== 14'd0) begin
            errors++;
            $display("FAIL async_reset: outputs=%b, required all 0",
                     {oRD_VALID, oRD_DATA, oERR_PARITY, oERR_FRAME, oERR_TIMEOUT, oERR_OVERFLOW, oBUSY});
        end
        wait_cycles(3);
        inRESET = 1'b1;
        m_valid = 1'b0;
        m_data  = 8'h00;
        wait_cycles(10);
        send_frame(8'h3A, odd_par(8'h3A), 1'b1, 1'b0);
        iRESET_SYNC = 1'b1;
        wait_cycles(1);
        iRESET_SYNC = 1'b0;
        m_valid = 1'b0;
        m_data  = 8'h00;
        checks++;
        if (oRD_VALID !== 1'b0 || oRD_DATA !== 8'h00 || oBUSY !== 1'b0) begin
            errors++;
            $display("FAIL sync_reset: valid=%b data=%h busy=%b, required 0, 00, 0", oRD_VALID, oRD_DATA, oBUSY);
        end
        wait_cycles(5);
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic bad, stp, ack;
        for (int k = 0; k < 8; k++) begin
            d   = 8'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            stp = ($urandom_range(0, 4) != 0);
            ack = 1'($urandom_range(0, 1));
            send_frame(d, odd_par(d) ^ bad, stp, ack);
            if ($urandom_range(0, 2) == 0) do_ack();
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (n_multi != 0) begin
            errors++;
            $display("FAIL exclusive_errors: cycles with several pulses=%0d, required 0", n_multi);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_frame();
        test_timeout();
        test_overflow();
        test_glitch_reset();
        test_random();
        test_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
